// File: rtl/kf8259_irq_sequencer_pkg.sv
// Shared helpers and types for the KF8259 interrupt sequencer.
// Priority helpers work in a rotated domain where bit 0 is always the highest priority.
package kf8259_irq_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK1 = 2'd2
  } seq_state_e;

  // Rotate so the level just above lowest_prio lands in bit 0 (lowest_prio == 7 is identity).
  function automatic logic [7:0] rotate_right(input logic [7:0] src, input logic [2:0] lowest);
    logic [15:0] dbl;
    logic [3:0]  amt;
    amt = {1'b0, lowest} + 4'd1;
    dbl = {src, src} >> amt;
    return dbl[7:0];
  endfunction

  // Inverse of rotate_right.
  function automatic logic [7:0] rotate_left(input logic [7:0] src, input logic [2:0] lowest);
    logic [15:0] dbl;
    logic [3:0]  amt;
    amt = {1'b0, lowest} + 4'd1;
    dbl = {src, src} << amt;
    return dbl[15:8];
  endfunction

  // Keep only the lowest set bit (highest priority in the rotated domain).
  function automatic logic [7:0] resolv_priority(input logic [7:0] req);
    return req & (~req + 8'd1);
  endfunction

  function automatic logic [7:0] num2bit(input logic [2:0] num);
    return 8'd1 << num;
  endfunction

  // Index of the lowest set bit; 0 for an empty input.
  function automatic logic [2:0] bit2num(input logic [7:0] onehot);
    logic [2:0] num;
    num = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (onehot[i]) num = 3'(i);
    end
    return num;
  endfunction

endpackage

// File: rtl/kf8259_priority_pick.sv
// Picks the highest-priority set bit of a request vector under rotating priority.
// rank_o is the rotated index of the pick (0 = most urgent), used to compare two picks.
module kf8259_priority_pick
  import kf8259_irq_sequencer_pkg::*;
(
  input  logic [7:0] req_i,
  input  logic [2:0] lowest_prio_i,
  output logic [7:0] pick_o,
  output logic [2:0] rank_o,
  output logic       any_o
);

  logic [7:0] rot_req;
  logic [7:0] rot_win;

  // Rotate into the priority domain, isolate the winner, rotate back.
  always_comb begin
    rot_req = rotate_right(req_i, lowest_prio_i);
    rot_win = resolv_priority(rot_req);
    pick_o  = rotate_left(rot_win, lowest_prio_i);
    rank_o  = bit2num(rot_win);
    any_o   = |req_i;
  end

endmodule

// File: rtl/kf8259_irq_sequencer.sv
// KF8259 interrupt arbiter and INTA sequencer: IRR/ISR bookkeeping, rotating priority,
// two-pulse acknowledge returning a vector, and non-specific / specific EOI handling.
module kf8259_irq_sequencer
  import kf8259_irq_sequencer_pkg::*;
#(
  parameter bit EDGE_TRIGGERED = 1'b1,
  parameter bit AUTO_EOI       = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] irq_req,
  input  logic [7:0] imr,
  input  logic [4:0] vector_base,
  input  logic       inta,
  input  logic       eoi,
  input  logic       specific_eoi,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic       set_priority,
  output logic       int_out,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [2:0] lowest_prio
);

  seq_state_e state_q, state_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lowest_prio_q, lowest_prio_d;
  logic       int_out_q, int_out_d;
  logic [7:0] vector_out_q, vector_out_d;
  logic       vector_valid_q, vector_valid_d;
  logic [7:0] sel_q, sel_d;
  logic       spurious_q, spurious_d;
  logic [7:0] irq_prev_q;

  logic [7:0] cand;
  logic [7:0] win;
  logic [7:0] ishi;
  logic [2:0] win_rank;
  logic [2:0] ishi_rank;
  logic       cand_any;
  logic       isr_any;
  logic       req_ok;
  logic [7:0] irr_clr;
  logic [7:0] isr_clr;
  logic [7:0] isr_set;

  assign cand = irr_q & ~imr;

  kf8259_priority_pick u_pick_cand (
    .req_i         (cand),
    .lowest_prio_i (lowest_prio_q),
    .pick_o        (win),
    .rank_o        (win_rank),
    .any_o         (cand_any)
  );

  kf8259_priority_pick u_pick_isr (
    .req_i         (isr_q),
    .lowest_prio_i (lowest_prio_q),
    .pick_o        (ishi),
    .rank_o        (ishi_rank),
    .any_o         (isr_any)
  );

  // A request is raised only if it strictly outranks everything already in service.
  assign req_ok = cand_any && (!isr_any || (win_rank < ishi_rank));

  // Sequencer next state, register updates and command handling.
  always_comb begin
    state_d        = state_q;
    int_out_d      = int_out_q;
    vector_out_d   = vector_out_q;
    vector_valid_d = 1'b0;
    sel_d          = sel_q;
    spurious_d     = spurious_q;
    lowest_prio_d  = lowest_prio_q;
    irr_clr        = 8'h00;
    isr_clr        = 8'h00;
    isr_set        = 8'h00;

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          state_d   = REQ;
          int_out_d = 1'b1;
        end
      end
      REQ: begin
        // int_out is held even if the request vanishes; only INTA retires it.
        if (inta) begin
          state_d   = ACK1;
          int_out_d = 1'b0;
          if (win != 8'h00) begin
            sel_d      = win;
            spurious_d = 1'b0;
            isr_set    = win;
            irr_clr    = win;
          end else begin
            sel_d      = 8'h80;
            spurious_d = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          state_d        = IDLE;
          vector_out_d   = {vector_base, bit2num(sel_q)};
          vector_valid_d = 1'b1;
          if (AUTO_EOI && !spurious_q) begin
            isr_clr = sel_q;
            if (rotate_on_eoi) lowest_prio_d = bit2num(sel_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Command strobes, evaluated against the pre-update ISR; lower-precedence strobes are dropped.
    if (specific_eoi) begin
      isr_clr = isr_clr | num2bit(eoi_level);
      if (rotate_on_eoi) lowest_prio_d = eoi_level;
    end else if (eoi) begin
      if (isr_any) begin
        isr_clr = isr_clr | ishi;
        if (rotate_on_eoi) lowest_prio_d = bit2num(ishi);
      end
    end else if (set_priority) begin
      lowest_prio_d = eoi_level;
    end

    // The acknowledge set is applied after any clear so a same-cycle EOI cannot undo it.
    isr_d = (isr_q & ~isr_clr) | isr_set;

    // An acknowledge clear beats a same-cycle edge on the same line.
    if (EDGE_TRIGGERED) begin
      irr_d = (irr_q | (irq_req & ~irq_prev_q)) & ~irr_clr;
    end else begin
      irr_d = irq_req & ~irr_clr;
    end
  end

  // State and register file.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      irr_q          <= 8'h00;
      isr_q          <= 8'h00;
      lowest_prio_q  <= 3'd7;
      int_out_q      <= 1'b0;
      vector_out_q   <= 8'h00;
      vector_valid_q <= 1'b0;
      sel_q          <= 8'h00;
      spurious_q     <= 1'b0;
      irq_prev_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      irr_q          <= irr_d;
      isr_q          <= isr_d;
      lowest_prio_q  <= lowest_prio_d;
      int_out_q      <= int_out_d;
      vector_out_q   <= vector_out_d;
      vector_valid_q <= vector_valid_d;
      sel_q          <= sel_d;
      spurious_q     <= spurious_d;
      irq_prev_q     <= irq_req;
    end
  end

  assign int_out      = int_out_q;
  assign vector_out   = vector_out_q;
  assign vector_valid = vector_valid_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign lowest_prio  = lowest_prio_q;

endmodule
